mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/mem_responder_if.sv | 35 +++
 rtl/sp_ram.sv | 27 ++
 rtl/mem_responder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory responder slice.
// Holds the default RAM depth, bus widths, FSM state encodings and byte-lane helpers.
// No logic of its own; imported by the interface, the RAM wrapper users and the top.
package cpu_pkg;

  localparam int DEF_MEMORY_SIZE = 32;  // RAM depth in 16-bit words
  localparam int BYTE_ADDR_W     = 8;   // load/store byte address width
  localparam int WORD_W          = 16;  // RAM word / instruction width
  localparam int BYTE_W          = 8;

  // FSM encoding kept as plain constants so older tools and dumps read it directly
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_READ      = 3'd1;
  localparam state_t ST_RMW_READ  = 3'd2;
  localparam state_t ST_RMW_WRITE = 3'd3;
  localparam state_t ST_RESP      = 3'd4;

  // Pick one byte lane out of a word: hi = 1 selects [15:8]
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  // Replace one byte lane of a word, keeping the other lane intact
  function automatic logic [WORD_W-1:0] merge_byte(input logic [WORD_W-1:0] w, input logic hi,
                                                   input logic [BYTE_W-1:0] b);
    return hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the fetch port and the load/store request/response channels.
// master = CPU side (issues fetches and requests), slave = memory responder.
// Request uses valid/ready; response is held valid until the CPU takes it.
interface mem_responder_if #(
  parameter int WA_W = $clog2(cpu_pkg::DEF_MEMORY_SIZE)
);
  import cpu_pkg::*;

  logic                   fetch_req;
  logic [WA_W-1:0]        fetch_addr;
  logic                   fetch_valid;
  logic [WORD_W-1:0]      fetch_data;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [BYTE_ADDR_W-1:0] req_addr;
  logic [BYTE_W-1:0]      req_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [BYTE_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  modport master (
    output fetch_req, fetch_addr, req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  fetch_valid, fetch_data, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  fetch_req, fetch_addr, req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output fetch_valid, fetch_data, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sp_ram.sv
// Single-port word RAM: one read or one write per cycle, synchronous read.
// Latency: read data appears the cycle after en && !we; rdata holds until the next read.
// No backpressure; contents are not reset.
module sp_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Single access port: a write does not disturb the last read value
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte load/store responder plus instruction fetch port sharing one single-port word RAM.
// Latency: fetch 1 cycle, load 2, store 3 (read-modify-write), out-of-range 1, from acceptance.
// Backpressure: req_ready only in IDLE; response held until rsp_ready; requests beat fetches.
module mem_responder #(
  parameter int MEMORY_SIZE = cpu_pkg::DEF_MEMORY_SIZE,
  parameter int WA_W        = $clog2(MEMORY_SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  import cpu_pkg::*;

  state_t            state;
  state_t            state_nxt;

  // Request captured at acceptance so later input changes are ignored
  logic              lat_write;
  logic              lat_hi;
  logic              lat_err;
  logic [WA_W-1:0]   lat_word;
  logic [BYTE_W-1:0] lat_wdata;

  logic              fetch_vld_q;
  logic              accept;
  logic              in_range;
  logic              fetch_go;

  logic              ram_en;
  logic              ram_we;
  logic [WA_W-1:0]   ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = (32'(bus.req_addr[7:1]) < 32'(MEMORY_SIZE));
  // A fetch only gets the RAM when the IDLE cycle is not taken by a request
  assign fetch_go      = bus.fetch_req && (state == ST_IDLE) && !bus.req_valid;

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!in_range)         state_nxt = ST_RESP;
          else if (bus.req_write) state_nxt = ST_RMW_READ;
          else                   state_nxt = ST_READ;
        end
      end
      ST_READ:      state_nxt = ST_RESP;
      ST_RMW_READ:  state_nxt = ST_RMW_WRITE;
      ST_RMW_WRITE: state_nxt = ST_RESP;
      ST_RESP:      if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight read-modify-write before its write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request fields on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_hi    <= 1'b0;
      lat_err   <= 1'b0;
      lat_word  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= bus.req_write;
      lat_hi    <= bus.req_addr[0];
      lat_err   <= !in_range;
      lat_word  <= WA_W'(bus.req_addr[7:1]);
      lat_wdata <= bus.req_wdata;
    end
  end

  // Fetch data is valid exactly one cycle after the RAM read it issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_vld_q <= 1'b0;
    else        fetch_vld_q <= fetch_go;
  end

  // RAM port arbitration: at most one access per cycle, chosen by state
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = lat_word;
    ram_wdata = merge_byte(ram_rdata, lat_hi, lat_wdata);
    case (state)
      ST_IDLE: begin
        if (fetch_go) begin
          ram_en   = 1'b1;
          ram_addr = bus.fetch_addr;
        end
      end
      ST_READ, ST_RMW_READ: ram_en = 1'b1;
      ST_RMW_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ram_en = 1'b0;
    endcase
  end

  sp_ram #(
    .DEPTH (MEMORY_SIZE),
    .AW    (WA_W),
    .DW    (WORD_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM read data stays put in RESP (no access there), so outputs decode it directly
  assign bus.fetch_valid = fetch_vld_q;
  assign bus.fetch_data  = fetch_vld_q ? ram_rdata : '0;
  assign bus.rsp_valid   = (state == ST_RESP);
  assign bus.rsp_err     = (state == ST_RESP) && lat_err;
  assign bus.rsp_rdata   = ((state == ST_RESP) && !lat_write && !lat_err) ?
                           sel_byte(ram_rdata, lat_hi) : '0;

endmodule
